// File: rtl/contador_multi_if.sv
// Pop/read bus of the multi-channel FIFO pop counter.
// master drives pops and read requests; slave returns registered counter reads.
interface contador_multi_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned IDX_W = 2
);
  logic [N_CH-1:0]  pop;
  logic [IDX_W-1:0] idx;
  logic             req;
  logic             req_all;
  logic             IDLE;
  logic             valid_contador;
  logic [CNT_W-1:0] contador_out;
  logic [IDX_W-1:0] idx_out;
  logic             ovf_out;
  logic             busy;

  modport master (
    output pop, idx, req, req_all, IDLE,
    input  valid_contador, contador_out, idx_out, ovf_out, busy
  );

  modport slave (
    input  pop, idx, req, req_all, IDLE,
    output valid_contador, contador_out, idx_out, ovf_out, busy
  );
endinterface

// File: rtl/contador_multi.sv
// Per-channel FIFO pop counters with sticky overflow flags.
// Supports single reads and full sweeps, with one-cycle registered read latency.
module contador_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned SAT_MODE    = 0,
  parameter int unsigned CLR_ON_READ = 0
) (
  input  logic               clk,
  input  logic               reset,
  contador_multi_if.slave    bus
);

  localparam int unsigned     PTR_W   = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] N_CH_P  = PTR_W'(N_CH);

  typedef enum logic [0:0] {S_IDLE, S_SWEEP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic             ovf_q [N_CH];

  logic             accept_all, accept_one, sweep_more;
  logic             samp_en;
  logic [IDX_W-1:0] samp_ch;
  logic [CNT_W-1:0] cnt_sel;
  logic             ovf_sel;

  logic             valid_q;
  logic [CNT_W-1:0] cnt_out_q;
  logic [IDX_W-1:0] idx_out_q;
  logic             ovf_out_q;

  // req_all wins over req; out-of-range single reads are dropped.
  assign accept_all = bus.IDLE && bus.req_all;
  assign accept_one = bus.IDLE && bus.req && !bus.req_all && (PTR_W'(bus.idx) < N_CH_P);
  assign sweep_more = ptr_q < N_CH_P;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept_all) state_d = S_SWEEP;
      S_SWEEP: if (!sweep_more) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ptr_q is the next channel a sweep will sample; channel 0 is taken on the accept edge.
  always_comb begin
    samp_en = 1'b0;
    samp_ch = '0;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        ptr_d = '0;
        if (accept_all) begin
          samp_en = 1'b1;
          samp_ch = '0;
          ptr_d   = PTR_W'(1);
        end else if (accept_one) begin
          samp_en = 1'b1;
          samp_ch = bus.idx;
        end
      end
      S_SWEEP: begin
        if (sweep_more) begin
          samp_en = 1'b1;
          samp_ch = ptr_q[IDX_W-1:0];
          ptr_d   = ptr_q + PTR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_sel = '0;
    ovf_sel = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (samp_ch == IDX_W'(i)) begin
        cnt_sel = cnt_q[i];
        ovf_sel = ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      cnt_out_q <= '0;
      idx_out_q <= '0;
      ovf_out_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      valid_q   <= samp_en;
      cnt_out_q <= samp_en ? cnt_sel : '0;
      idx_out_q <= samp_en ? samp_ch : '0;
      ovf_out_q <= samp_en ? ovf_sel : 1'b0;
      ptr_q     <= ptr_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic clr_hit;
    assign clr_hit = (CLR_ON_READ != 0) && samp_en && (samp_ch == IDX_W'(g));

    // Clear-on-read loads the concurrent pop so it is not lost.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q[g] <= '0;
        ovf_q[g] <= 1'b0;
      end else if (clr_hit) begin
        cnt_q[g] <= CNT_W'(bus.pop[g]);
        ovf_q[g] <= 1'b0;
      end else if (bus.pop[g]) begin
        if (cnt_q[g] == CNT_MAX) begin
          ovf_q[g] <= 1'b1;
          cnt_q[g] <= (SAT_MODE != 0) ? CNT_MAX : '0;
        end else begin
          cnt_q[g] <= cnt_q[g] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.valid_contador = valid_q;
  assign bus.contador_out   = cnt_out_q;
  assign bus.idx_out        = idx_out_q;
  assign bus.ovf_out        = ovf_out_q;
  assign bus.busy           = (state_q == S_SWEEP);

endmodule
